keypad_emulator: RTL and testbench

Bench-side and FPGA-loopback model of the 4x4 matrix keypad that the calculator's input controller scans. It watches the column drive and answers on the row lines as a physical keypad would. It presses one requested key at a time, with optional contact bounce, a programmable hold time and a release gap. Presses are requested over a valid/ready handshake, so a sequencer can type whole expressions into the calculator.

---
 rtl/keypad_req_if.sv | 20 ++
 rtl/keypad_emulator.sv | 107 ++++++++++
 tb/tb_keypad_emulator.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/keypad_req_if.sv
// Press-request channel between a key sequencer and the keypad emulator.
// The sequencer drives the request; the emulator reports readiness and progress.
interface keypad_req_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_row;
  logic [1:0] req_col;
  logic       busy;
  logic       done;

  modport master (
    output req_valid, req_row, req_col,
    input  req_ready, busy, done
  );

  modport slave (
    input  req_valid, req_row, req_col,
    output req_ready, busy, done
  );
endinterface

// File: rtl/keypad_emulator.sv
// 4x4 active-low matrix keypad model: presses one requested key with optional
// contact bounce, a hold time and a release gap, answering the column scan on row.
module keypad_emulator #(
  parameter int HOLD_CYCLES   = 64,
  parameter int GAP_CYCLES    = 32,
  parameter int BOUNCE_CYCLES = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      col,
  output logic [3:0]      row,
  output logic            key_active,
  keypad_req_if.slave     req
);

  localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_CYC = (MAX_HG > BOUNCE_CYCLES) ? MAX_HG : BOUNCE_CYCLES;
  localparam int CNT_RAW = $clog2(MAX_CYC + 1);
  // The bounce pattern reads cnt[1], so the counter is never narrower than 2 bits.
  localparam int CNT_W   = (CNT_RAW < 2) ? 2 : CNT_RAW;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    BOUNCE_IN  = 3'd1,
    HOLD       = 3'd2,
    BOUNCE_OUT = 3'd3,
    GAP        = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             contact_q, contact_d;
  logic [1:0]       key_r_q, key_r_d;
  logic [1:0]       key_c_q, key_c_d;
  logic             handshake;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Bounce toggles every two cycles, starting closed on entry.
  function automatic logic contact_of(input state_t s, input logic [CNT_W-1:0] c);
    case (s)
      BOUNCE_IN, BOUNCE_OUT: return ~c[1];
      HOLD:                  return 1'b1;
      default:               return 1'b0;
    endcase
  endfunction

  assign handshake = req.req_valid && req.req_ready;

  always_comb begin
    state_d = state_q;
    key_r_d = key_r_q;
    key_c_d = key_c_q;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          key_r_d = req.req_row;
          key_c_d = req.req_col;
          state_d = (BOUNCE_CYCLES == 0) ? HOLD : BOUNCE_IN;
        end
      end
      BOUNCE_IN:  if (cnt_q == BOUNCE_LAST) state_d = HOLD;
      HOLD:       if (cnt_q == HOLD_LAST)   state_d = (BOUNCE_CYCLES == 0) ? GAP : BOUNCE_OUT;
      BOUNCE_OUT: if (cnt_q == BOUNCE_LAST) state_d = GAP;
      GAP:        if (cnt_q == GAP_LAST)    state_d = IDLE;
      default:    state_d = IDLE;
    endcase
    cnt_d     = (state_d != state_q) ? '0 : sat_inc(cnt_q);
    contact_d = contact_of(state_d, cnt_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      contact_q <= 1'b0;
      key_r_q   <= 2'd0;
      key_c_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      contact_q <= contact_d;
      key_r_q   <= key_r_d;
      key_c_q   <= key_c_d;
    end
  end

  assign req.req_ready = (state_q == IDLE);
  assign req.busy      = (state_q != IDLE);
  assign req.done      = (state_q == GAP) && (cnt_q == GAP_LAST);
  assign key_active    = contact_q;

  // Unregistered path from col so a scanner sees the key in the cycle it drives the column.
  always_comb begin
    row = 4'hF;
    for (int i = 0; i < 4; i++) begin
      if (contact_q && (2'(i) == key_r_q) && !col[key_c_q]) row[i] = 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: one instance without bounce, one with bounce.
module tb_keypad_emulator;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] col0, col1;
  logic [3:0] row0, row1;
  logic       ka0, ka1;
  int         n_chk = 0;
  int         n_fail = 0;

  keypad_req_if bus0();
  keypad_req_if bus1();

  keypad_emulator #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .BOUNCE_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .col(col0), .row(row0), .key_active(ka0), .req(bus0.slave)
  );

  keypad_emulator #(.HOLD_CYCLES(6), .GAP_CYCLES(3), .BOUNCE_CYCLES(8)) dut1 (
    .clk(clk), .reset(reset), .col(col1), .row(row1), .key_active(ka1), .req(bus1.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press0(input logic [1:0] r, input logic [1:0] c);
    @(negedge clk);
    check("dut0 ready before press", 32'(bus0.req_ready), 32'd1);
    bus0.req_valid = 1'b1; bus0.req_row = r; bus0.req_col = c;
    @(posedge clk);
    #1 bus0.req_valid = 1'b0;
  endtask

  task automatic press1(input logic [1:0] r, input logic [1:0] c);
    @(negedge clk);
    check("dut1 ready before press", 32'(bus1.req_ready), 32'd1);
    bus1.req_valid = 1'b1; bus1.req_row = r; bus1.req_col = c;
    @(posedge clk);
    #1 bus1.req_valid = 1'b0;
  endtask

  function automatic logic exp_bounce_row0(input int k);
    if (k <= 8)  return logic'(((k - 1) >> 1) & 1);
    if (k <= 14) return 1'b0;
    if (k <= 22) return logic'(((k - 15) >> 1) & 1);
    return 1'b1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int first_done, second_done, done_cnt;
    bus0.req_valid = 1'b0; bus0.req_row = 2'd0; bus0.req_col = 2'd0;
    bus1.req_valid = 1'b0; bus1.req_row = 2'd0; bus1.req_col = 2'd0;
    col0 = 4'hF; col1 = 4'hF;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst row0", 32'(row0), 32'hF);
    check("rst row1", 32'(row1), 32'hF);
    check("rst ready0", 32'(bus0.req_ready), 32'd1);
    check("rst busy0", 32'(bus0.busy), 32'd0);
    check("rst ka0", 32'(ka0), 32'd0);
    check("rst done0", 32'(bus0.done), 32'd0);
    check("rst busy1", 32'(bus1.busy), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Basic press (1,2), column 2 driven
    col0 = 4'b1011;
    press0(2'd1, 2'd2);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("basic row k=%0d", k), 32'(row0), (k <= 4) ? 32'hD : 32'hF);
      check($sformatf("basic done k=%0d", k), 32'(bus0.done), (k == 6) ? 32'd1 : 32'd0);
      check($sformatf("basic ready k=%0d", k), 32'(bus0.req_ready), (k == 7) ? 32'd1 : 32'd0);
    end

    // Same key, a different column scanned: contact closes but rows stay idle
    col0 = 4'b1101;
    press0(2'd1, 2'd2);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("wrongcol row k=%0d", k), 32'(row0), 32'hF);
      if (k == 2) check("wrongcol ka", 32'(ka0), 32'd1);
    end

    // Bounce on key (0,0)
    col1 = 4'b1110;
    press1(2'd0, 2'd0);
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      check($sformatf("bounce row k=%0d", k), 32'(row1), 32'({3'b111, exp_bounce_row0(k)}));
      if (k == 1) check("bounce busy", 32'(bus1.busy), 32'd1);
      if (k == 25) check("bounce done", 32'(bus1.done), 32'd1);
      if (k == 24) check("bounce done early", 32'(bus1.done), 32'd0);
      if (k == 26) check("bounce ready", 32'(bus1.req_ready), 32'd1);
    end

    // Back-to-back: valid held high, fields change while busy
    col0 = 4'b0101;
    @(negedge clk);
    bus0.req_valid = 1'b1; bus0.req_row = 2'd2; bus0.req_col = 2'd3;
    @(posedge clk);
    #1 bus0.req_row = 2'd3; bus0.req_col = 2'd1;
    first_done = -1; second_done = -1; done_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus0.done) begin
        done_cnt++;
        if (first_done < 0) first_done = k; else if (second_done < 0) second_done = k;
      end
      if (k == 2) check("b2b first key row", 32'(row0), 32'hB);
      if (k == 3) check("b2b ready while busy", 32'(bus0.req_ready), 32'd0);
      if (k == 9) check("b2b second key row", 32'(row0), 32'h7);
      if (k == 8) bus0.req_valid = 1'b0;
    end
    check("b2b first done", 32'(first_done), 32'd6);
    check("b2b spacing", 32'(second_done - first_done), 32'd7);
    check("b2b done count", 32'(done_cnt), 32'd2);

    // All columns driven low during the hold of (3,2); col changes mid-cycle
    col0 = 4'b1011;
    press0(2'd3, 2'd2);
    @(negedge clk); @(negedge clk);
    check("multicol base", 32'(row0), 32'h7);
    col0 = 4'b0000; #1;
    check("multicol all low", 32'(row0), 32'h7);
    col0 = 4'b0100; #1;
    check("multicol key col high", 32'(row0), 32'hF);
    col0 = 4'b1011; #1;
    check("multicol restore", 32'(row0), 32'h7);
    repeat (8) @(negedge clk);

    // Asynchronous reset in the middle of HOLD
    col1 = 4'b1101;
    press1(2'd1, 2'd1);
    for (int k = 1; k <= 10; k++) @(negedge clk);
    check("midhold ka", 32'(ka1), 32'd1);
    check("midhold row", 32'(row1), 32'hD);
    #2 reset = 1'b0;
    #1;
    check("async rst row", 32'(row1), 32'hF);
    check("async rst ka", 32'(ka1), 32'd0);
    check("async rst busy", 32'(bus1.busy), 32'd0);
    check("async rst done", 32'(bus1.done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    done_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus1.done) done_cnt++;
    end
    check("post rst no done", 32'(done_cnt), 32'd0);
    check("post rst ready", 32'(bus1.req_ready), 32'd1);
    check("post rst row", 32'(row1), 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
